axi_lite_wr_arbiter: RTL and testbench
======================================

Name: axi_lite_wr_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite slave write port (AW/W/B) between NUM_M AXI4-Lite masters.
- Allows one outstanding write at a time. The grant is held from AW/W acceptance through the B handshake.
- Sits between the bench/system masters and the shared slave interface. The slave-side port must satisfy the existing valid-stability assertions (valid && !ready |=> valid) on AW, W and B.

Parameters:
NUM_M, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
m_awaddr  in  NUM_M*ADDR_W  packed master write addresses, master i at slice i
m_awvalid  in  NUM_M  master AW valid
m_awready  out  NUM_M  master AW ready
m_wdata  in  NUM_M*DATA_W  packed master write data
m_wstrb  in  NUM_M*DATA_W/8  packed master write strobes
m_wvalid  in  NUM_M  master W valid
m_wready  out  NUM_M  master W ready
m_bresp  out  NUM_M*2  packed responses; every slice carries s_bresp
m_bvalid  out  NUM_M  master B valid
m_bready  in  NUM_M  master B ready
s_awaddr  out  ADDR_W  slave write address
s_awvalid  out  1  slave AW valid
s_awready  in  1  slave AW ready
s_wdata  out  DATA_W  slave write data
s_wstrb  out  DATA_W/8  slave write strobe
s_wvalid  out  1  slave W valid
s_wready  in  1  slave W ready
s_bresp  in  2  slave write response
s_bvalid  in  1  slave B valid
s_bready  out  1  slave B ready
grant_id  out  $clog2(NUM_M)  index of the currently/last granted master
busy  out  1  high in XFER and RESP

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, aw_done=w_done=0, grant_id=0, last_grant=NUM_M-1 so master 0 has first priority.
  - All *valid and *ready outputs are 0; busy=0. s_awaddr/s_wdata/s_wstrb are muxed from grant_id.
- Request: master i requests when m_awvalid[i]=1. W-before-AW does not request.
- FSM IDLE: if any request, pick the first requester scanning last_grant+1, +2, ... modulo NUM_M. Register it into grant_id; go to XFER next cycle. Latency from m_awvalid to s_awvalid is 1 cycle. No forwarding in IDLE.
- FSM XFER (g=grant_id):
  - s_awvalid = m_awvalid[g] && !aw_done; m_awready[g] = s_awready && !aw_done.
  - s_wvalid = m_wvalid[g] && !w_done; m_wready[g] = s_wready && !w_done.
  - Each handshake sets its done flag. AW and W complete independently, in either order or the same cycle.
  - When both are done (including a same-cycle final handshake), go to RESP and clear the done flags.
- FSM RESP: m_bvalid[g]=s_bvalid, s_bready=m_bready[g]. On s_bvalid && s_bready, set last_grant=g and return to IDLE.
- Non-granted masters always see ready=0 and bvalid=0. s_bready=0 and m_bvalid=0 outside RESP; a slave B outside RESP is held off.
- Grant never changes in XFER/RESP, so a master holding valid keeps s_*valid stable. This guarantees slave-side valid stability.
- Back-to-back: the earliest new grant is the cycle after the B handshake (IDLE is one cycle). Sustained throughput is 1 write per (3 + slave latency) cycles.
- Reset mid-XFER/RESP: all outputs drop to reset values immediately. An in-flight transaction is abandoned; the bench must reset the slave too.
- NUM_M=1: arbitration is degenerate; grant_id is 1 bit, held 0.

Test Plan:
- Single master 0 writes addr 0x10, data 0xDEADBEEF, strb 0xF; slave readies immediately -> s_awvalid rises 1 cycle after m_awvalid, OKAY on m_bresp[1:0], m_bvalid[1] never high, busy high 3 cycles.
- Masters 0 and 1 request in the same cycle, 4 writes each held continuously -> grants alternate 0,1,0,1,...; each master gets exactly 4 B responses.
- Master 1 W valid 3 cycles before AW, slave s_awready delayed 5 cycles -> W accepted first, AW later, one RESP, data 0xA5A5A5A5 at the slave.
- Slave returns SLVERR (2'b10) with s_bvalid held 4 cycles while m_bready low -> s_bvalid/m_bvalid stable, bresp propagated, no new grant until the handshake.
- Assert rst_n low mid-XFER with master 0 granted -> s_awvalid/s_wvalid/busy 0 asynchronously; after release, master 0 wins the first grant again.
- Random valid/ready stalls on all masters for 1000 writes -> bound valid-stability assertions never fire, slave write count equals the sum of master B counts.

Source files
------------

// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write slave (AW/W/B) among NUM_M masters.
// One write is outstanding at a time; the grant is held from AW/W acceptance through the B handshake.
module axi_lite_wr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_M*ADDR_W-1:0]                      m_awaddr,
    input  logic [NUM_M-1:0]                             m_awvalid,
    output logic [NUM_M-1:0]                             m_awready,
    input  logic [NUM_M*DATA_W-1:0]                      m_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]                    m_wstrb,
    input  logic [NUM_M-1:0]                             m_wvalid,
    output logic [NUM_M-1:0]                             m_wready,
    output logic [NUM_M*2-1:0]                           m_bresp,
    output logic [NUM_M-1:0]                             m_bvalid,
    input  logic [NUM_M-1:0]                             m_bready,
    output logic [ADDR_W-1:0]                            s_awaddr,
    output logic                                         s_awvalid,
    input  logic                                         s_awready,
    output logic [DATA_W-1:0]                            s_wdata,
    output logic [DATA_W/8-1:0]                          s_wstrb,
    output logic                                         s_wvalid,
    input  logic                                         s_wready,
    input  logic [1:0]                                   s_bresp,
    input  logic                                         s_bvalid,
    output logic                                         s_bready,
    output logic [((NUM_M > 1) ? $clog2(NUM_M) : 1)-1:0] grant_id,
    output logic                                         busy
);
    localparam int          GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int          SW = DATA_W / 8;
    localparam int unsigned NM = NUM_M;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

    state_e        state_q, state_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] cand;
    logic          found;
    logic          aw_hs, w_hs, b_hs;

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_awaddr  = m_awaddr[int'(grant_q)*ADDR_W +: ADDR_W];
        s_wdata   = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
        s_wstrb   = m_wstrb[int'(grant_q)*SW +: SW];
        case (state_q)
            XFER: begin
                s_awvalid          = m_awvalid[grant_q] && !aw_done_q;
                m_awready[grant_q] = s_awready && !aw_done_q;
                s_wvalid           = m_wvalid[grant_q] && !w_done_q;
                m_wready[grant_q]  = s_wready && !w_done_q;
            end
            RESP: begin
                m_bvalid[grant_q] = s_bvalid;
                s_bready          = m_bready[grant_q];
            end
            default: ;
        endcase
    end

    assign m_bresp  = {NUM_M{s_bresp}};
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign aw_hs    = s_awvalid && s_awready;
    assign w_hs     = s_wvalid && s_wready;
    assign b_hs     = s_bvalid && s_bready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        grant_d   = grant_q;
        last_d    = last_q;
        found     = 1'b0;
        cand      = '0;
        case (state_q)
            IDLE: begin
                // Scan from the master after the last winner, wrapping modulo NUM_M.
                for (int unsigned k = 1; k <= NM; k++) begin
                    cand = GW'((32'(last_q) + k) % NM);
                    if (!found && m_awvalid[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) state_d = XFER;
            end
            XFER: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
            RESP: begin
                if (b_hs) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            grant_q   <= '0;
            last_q    <= GW'(NUM_M - 1);
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Randomized bench for axi_lite_wr_arbiter: master/slave drivers, a transaction scoreboard
// and a round-robin reference model checked by an independent monitor.
module tb_axi_lite_wr_arbiter;
    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NM*AW-1:0]      m_awaddr;
    logic [NM-1:0]         m_awvalid, m_awready;
    logic [NM*DW-1:0]      m_wdata;
    logic [NM*SW-1:0]      m_wstrb;
    logic [NM-1:0]         m_wvalid, m_wready;
    logic [NM*2-1:0]       m_bresp;
    logic [NM-1:0]         m_bvalid, m_bready;
    logic [AW-1:0]         s_awaddr;
    logic                  s_awvalid, s_awready;
    logic [DW-1:0]         s_wdata;
    logic [SW-1:0]         s_wstrb;
    logic                  s_wvalid, s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid, s_bready;
    logic [$clog2(NM)-1:0] grant_id;
    logic                  busy;

    axi_lite_wr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int m; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb;} wr_t;
    typedef struct {int m; logic [1:0] resp;} b_t;
    wr_t         exp_wr[$];
    b_t          exp_b[$];
    int unsigned exp_grant[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Knobs: a negative delay means random per write/cycle.
    int            n_todo[NM];
    int            k_aw_dly, k_w_dly, k_sa_dly, k_sw_dly, k_b_dly, k_br_dly, k_resp;
    bit            k_fix;
    logic [AW-1:0] k_addr;
    logic [DW-1:0] k_data;
    logic [SW-1:0] k_strb;
    int            issued[NM], b_cnt[NM], s_wr_cnt, last_busy_len, last_aw_cyc, last_w_cyc;

    bit act[NM], aw_sent[NM], w_sent[NM];
    int aw_cnt[NM], w_cnt[NM], bv_seen[NM];
    bit sl_aw, sl_w, sl_bp;
    int sl_m, sl_bcnt, sa_wait, sw_wait;

    task automatic chk(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    function automatic int rnd(input int k);
        return (k < 0) ? int'($urandom_range(3, 0)) : k;
    endfunction

    task automatic reset_bench();
        m_awvalid = '0; m_wvalid = '0; m_bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        for (int i = 0; i < NM; i++) begin
            act[i] = 0; aw_sent[i] = 0; w_sent[i] = 0; bv_seen[i] = 0;
        end
        sl_aw = 0; sl_w = 0; sl_bp = 0; sa_wait = 0; sw_wait = 0;
        exp_wr.delete(); exp_b.delete();
    endtask

    initial begin : drive
        logic [NM-1:0] aw_hs, w_hs, b_hs;
        logic          sa_hs, sw_hs, sb_hs, sav, swv;
        logic [AW-1:0] saddr, addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        reset_bench();
        forever begin
            @(negedge clk);
            aw_hs = m_awvalid & m_awready;
            w_hs  = m_wvalid & m_wready;
            b_hs  = m_bvalid & m_bready;
            sa_hs = s_awvalid && s_awready;
            sw_hs = s_wvalid && s_wready;
            sb_hs = s_bvalid && s_bready;
            sav = s_awvalid; swv = s_wvalid; saddr = s_awaddr;
            for (int i = 0; i < NM; i++) if (m_bvalid[i]) bv_seen[i]++;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                reset_bench();
                continue;
            end
            for (int i = 0; i < NM; i++) begin
                if (b_hs[i]) begin act[i] = 0; m_bready[i] = 1'b0; end
                if (aw_hs[i]) begin m_awvalid[i] = 1'b0; aw_sent[i] = 1; end
                if (w_hs[i]) begin m_wvalid[i] = 1'b0; w_sent[i] = 1; end
                if (!act[i] && n_todo[i] > 0) begin
                    act[i] = 1; aw_sent[i] = 0; w_sent[i] = 0; bv_seen[i] = 0;
                    aw_cnt[i] = rnd(k_aw_dly); w_cnt[i] = rnd(k_w_dly);
                    n_todo[i]--; issued[i]++;
                    addr = {4'(i), k_fix ? k_addr[AW-5:0] : 28'($urandom)};
                    data = k_fix ? k_data : DW'($urandom);
                    strb = k_fix ? k_strb : SW'($urandom_range(15, 1));
                    m_awaddr[i*AW +: AW] = addr;
                    m_wdata[i*DW +: DW]  = data;
                    m_wstrb[i*SW +: SW]  = strb;
                    exp_wr.push_back('{i, addr, data, strb});
                end
                if (act[i] && !aw_sent[i] && !m_awvalid[i]) begin
                    if (aw_cnt[i] == 0) m_awvalid[i] = 1'b1; else aw_cnt[i]--;
                end
                if (act[i] && !w_sent[i] && !m_wvalid[i]) begin
                    if (w_cnt[i] == 0) m_wvalid[i] = 1'b1; else w_cnt[i]--;
                end
                if (act[i] && aw_sent[i] && w_sent[i])
                    m_bready[i] = (k_br_dly < 0) ? 1'($urandom_range(1, 0)) : (bv_seen[i] >= k_br_dly);
                else
                    m_bready[i] = 1'b0;
            end
            if (sb_hs) begin s_bvalid = 1'b0; sl_bp = 0; sl_aw = 0; sl_w = 0; s_wr_cnt++; end
            if (sa_hs) begin sl_aw = 1; sl_m = int'(saddr[AW-1:AW-4]); sa_wait = 0; end
            else if (sav) sa_wait++;
            if (sw_hs) begin sl_w = 1; sw_wait = 0; end
            else if (swv) sw_wait++;
            s_awready = (k_sa_dly < 0) ? 1'($urandom_range(1, 0)) : (sa_wait >= k_sa_dly);
            s_wready  = (k_sw_dly < 0) ? 1'($urandom_range(1, 0)) : (sw_wait >= k_sw_dly);
            if (sl_aw && sl_w && !sl_bp) begin sl_bp = 1; sl_bcnt = rnd(k_b_dly); end
            if (sl_bp && !s_bvalid) begin
                if (sl_bcnt == 0) begin
                    s_bvalid = 1'b1;
                    s_bresp  = (k_resp < 0) ? 2'($urandom_range(3, 0)) : 2'(k_resp);
                    exp_b.push_back('{sl_m, s_bresp});
                end else sl_bcnt--;
            end
        end
    end

    initial begin : monitor
        logic [AW-1:0]   cap_addr, p_saddr;
        logic [DW-1:0]   cap_data, p_sdata;
        logic [SW-1:0]   cap_strb, p_sstrb;
        logic            p_sav, p_sar, p_swv, p_swr;
        logic [NM-1:0]   p_bv, p_br, mask;
        logic [NM*2-1:0] p_bresp;
        bit              got_aw, got_w, owned;
        int              owner, ref_last, busy_run, fj, m;
        int unsigned     g, c;
        got_aw = 0; got_w = 0; owned = 0; owner = 0; ref_last = NM - 1; busy_run = 0;
        p_sav = 0; p_sar = 0; p_swv = 0; p_swr = 0; p_bv = '0; p_br = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got_aw = 0; got_w = 0; owned = 0; ref_last = NM - 1; busy_run = 0;
                p_sav = 0; p_swv = 0; p_bv = '0;
                exp_grant.delete();
                continue;
            end
            if (exp_grant.size() > 0) begin
                g = exp_grant.pop_front();
                chk("grant_id", grant_id, g);
                chk("busy_after_req", busy, 1'b1);
                chk("aw_latency", s_awvalid, 1'b1);
                owner = int'(g);
                owned = 1;
            end else if (busy && owned) chk("grant_hold", grant_id, owner);
            mask = (busy && owned) ? NM'(1 << owner) : '0;
            chk("isolation", {m_awready & ~mask, m_wready & ~mask, m_bvalid & ~mask}, '0);
            if (p_sav && !p_sar) chk("aw_stable", {s_awvalid, s_awaddr}, {1'b1, p_saddr});
            if (p_swv && !p_swr) chk("w_stable", {s_wvalid, s_wdata, s_wstrb}, {1'b1, p_sdata, p_sstrb});
            for (int i = 0; i < NM; i++)
                if (p_bv[i] && !p_br[i])
                    chk("b_stable", {m_bvalid[i], m_bresp[2*i +: 2]}, {1'b1, p_bresp[2*i +: 2]});
            if (s_awvalid && s_awready) begin cap_addr = s_awaddr; got_aw = 1; last_aw_cyc = cyc; end
            if (s_wvalid && s_wready) begin
                cap_data = s_wdata; cap_strb = s_wstrb; got_w = 1; last_w_cyc = cyc;
            end
            if (got_aw && got_w) begin
                m = int'(cap_addr[AW-1:AW-4]);
                fj = -1;
                foreach (exp_wr[j]) if (fj < 0 && exp_wr[j].m == m) fj = j;
                chk("wr_expected", fj >= 0, 1'b1);
                if (fj >= 0) begin
                    chk("wr_payload", {cap_addr, cap_data, cap_strb},
                        {exp_wr[fj].addr, exp_wr[fj].data, exp_wr[fj].strb});
                    exp_wr.delete(fj);
                end
                got_aw = 0; got_w = 0;
            end
            for (int i = 0; i < NM; i++) begin
                if (m_bvalid[i] && m_bready[i]) begin
                    b_cnt[i]++;
                    fj = -1;
                    foreach (exp_b[j]) if (fj < 0 && exp_b[j].m == i) fj = j;
                    chk("b_expected", fj >= 0, 1'b1);
                    if (fj >= 0) begin
                        chk("bresp", m_bresp[2*i +: 2], exp_b[fj].resp);
                        exp_b.delete(fj);
                    end
                end
            end
            if (owned && m_bvalid[owner] && m_bready[owner]) ref_last = owner;
            // Reference round robin: first requester after the last completed winner.
            if (!busy && (|m_awvalid)) begin
                g = 0;
                for (int k = NM; k >= 1; k--) begin
                    c = unsigned'(ref_last + k) % NM;
                    if (m_awvalid[c]) g = c;
                end
                exp_grant.push_back(g);
            end
            if (busy) busy_run++;
            else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end
            p_sav = s_awvalid; p_sar = s_awready; p_saddr = s_awaddr;
            p_swv = s_wvalid; p_swr = s_wready; p_sdata = s_wdata; p_sstrb = s_wstrb;
            p_bv = m_bvalid; p_br = m_bready; p_bresp = m_bresp;
        end
    end

    task automatic set_knobs(input int aw, input int w, input int sa, input int sw,
                             input int b, input int br, input int resp);
        k_aw_dly = aw; k_w_dly = w; k_sa_dly = sa; k_sw_dly = sw;
        k_b_dly = b; k_br_dly = br; k_resp = resp;
    endtask

    task automatic run_phase(input string name, input int n0, input int n1, input int budget);
        bit done;
        int swr0;
        for (int i = 0; i < NM; i++) begin issued[i] = 0; b_cnt[i] = 0; end
        swr0 = s_wr_cnt;
        n_todo[0] = n0;
        n_todo[1] = n1;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = (n_todo[0] == 0) && (n_todo[1] == 0) && !act[0] && !act[1] && !sl_bp;
        end
        chk({name, "_done"}, done, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NM; i++) chk({name, "_b_count"}, b_cnt[i], issued[i]);
        chk({name, "_slave_writes"}, s_wr_cnt - swr0, b_cnt[0] + b_cnt[1]);
        chk({name, "_sb_empty"}, exp_wr.size() + exp_b.size(), 0);
    endtask

    initial begin : main
        n_todo[0] = 0; n_todo[1] = 0; s_wr_cnt = 0; last_busy_len = 0;
        last_aw_cyc = 0; last_w_cyc = 0;
        k_fix = 0; k_addr = '0; k_data = '0; k_strb = '0;
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_busy0", busy, 1'b0);
        chk("rst_grant0", grant_id, 1'b0);
        chk("rst_valids", {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        k_fix = 1; k_addr = 32'h10; k_data = 32'hDEADBEEF; k_strb = 4'hF;
        set_knobs(0, 0, 0, 0, 1, 0, 0);
        run_phase("single", 1, 0, 50);
        chk("single_busy_len", last_busy_len, 3);

        k_fix = 0;
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        run_phase("alternate", 4, 4, 200);

        k_fix = 1; k_addr = 32'h100; k_data = 32'hA5A5A5A5; k_strb = 4'hF;
        set_knobs(3, 0, 5, 0, 0, 0, 0);
        run_phase("w_first", 0, 1, 100);
        chk("w_before_aw", last_w_cyc < last_aw_cyc, 1'b1);

        k_fix = 0;
        set_knobs(0, 0, 0, 0, 0, 4, 2);
        run_phase("slverr", 1, 1, 100);

        set_knobs(0, 0, 20, 20, 0, 0, 0);
        n_todo[0] = 1;
        for (int c = 0; c < 50 && !(busy && grant_id == 0); c++) @(negedge clk);
        chk("rst_pre_grant", {busy, grant_id}, {1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_awvalid", s_awvalid, 1'b0);
        chk("rst_async_wvalid", s_wvalid, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        run_phase("post_reset", 1, 1, 100);

        set_knobs(-1, -1, -1, -1, -1, -1, -1);
        run_phase("random", 500, 500, 60000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
